// File: rtl/rids_result_serializer_if.sv
// Stream bundle between the bitonic merge tree, the RIDS serializer and the action lookup.
interface rids_result_serializer_if #(
  parameter int unsigned RID_WIDTH = 4,
  parameter int unsigned NUM_RID   = 8
);
  logic                           in_valid;
  logic [RID_WIDTH*NUM_RID-1:0]   in_rids;
  logic                           in_ready;
  logic                           out_valid;
  logic                           out_ready;
  logic [RID_WIDTH-1:0]           out_rid;
  logic                           out_last;
  logic                           out_nomatch;
  logic                           overflow;

  modport master (
    output in_valid, in_rids, out_ready,
    input  in_ready, out_valid, out_rid, out_last, out_nomatch, overflow
  );

  modport slave (
    input  in_valid, in_rids, out_ready,
    output in_ready, out_valid, out_rid, out_last, out_nomatch, overflow
  );
endinterface

// File: rtl/rids_result_serializer.sv
// Buffers merged RIDS words in a small FIFO and streams their rule IDs one per beat,
// lowest RID first, with a single no-match beat for an empty RIDS.
module rids_result_serializer #(
  parameter int unsigned RID_WIDTH   = 4,
  parameter int unsigned NUM_RID     = 8,
  parameter int unsigned LOG_NUM_RID = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LOG_FIFO    = 2
) (
  input logic                     clk,
  input logic                     reset,
  rids_result_serializer_if.slave bus
);

  localparam int unsigned RIDS_W = RID_WIDTH * NUM_RID;
  localparam int unsigned OCC_W  = LOG_FIFO + 1;
  localparam int unsigned CNT_W  = LOG_NUM_RID + 1;
  localparam logic [RID_WIDTH-1:0] NULL_RID = '1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [RIDS_W-1:0]      r_fifo [FIFO_DEPTH];
  logic [LOG_FIFO-1:0]    r_wr_ptr;
  logic [LOG_FIFO-1:0]    r_rd_ptr;
  logic [OCC_W-1:0]       r_occ;
  logic [LOG_NUM_RID-1:0] r_idx;
  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_overflow;
  logic                   r_out_valid;
  logic [RID_WIDTH-1:0]   r_out_rid;
  logic                   r_out_last;
  logic                   r_out_nomatch;

  logic                   w_push;
  logic                   w_beat;
  logic                   w_pop;
  logic [OCC_W-1:0]       w_occ_nxt;
  logic [LOG_FIFO-1:0]    w_rd_ptr_nxt;
  logic [LOG_FIFO-1:0]    w_wr_ptr_nxt;
  logic [LOG_NUM_RID-1:0] w_idx_nxt;
  logic [RIDS_W-1:0]      w_head_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_send_nxt;
  logic [RID_WIDTH-1:0]   w_rid_nxt;
  logic                   w_last_nxt;
  logic                   w_nomatch_nxt;

  // Number of valid RIDs: index of the first NULL slot, anything after it is ignored.
  function automatic logic [CNT_W-1:0] rids_count(input logic [RIDS_W-1:0] rids);
    logic [CNT_W-1:0] cnt;
    logic             found;
    cnt   = CNT_W'(NUM_RID);
    found = 1'b0;
    for (int j = 0; j < int'(NUM_RID); j++) begin
      if (!found && (rids[j*RID_WIDTH +: RID_WIDTH] == NULL_RID)) begin
        cnt   = CNT_W'(j);
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  // Next-state view; the head of the next cycle may be the word being written right now.
  always_comb begin
    w_push        = bus.in_valid && r_in_ready;
    w_beat        = (r_state == S_SEND) && bus.out_ready;
    w_pop         = w_beat && r_out_last;
    w_occ_nxt     = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    w_rd_ptr_nxt  = r_rd_ptr + LOG_FIFO'(w_pop);
    w_wr_ptr_nxt  = r_wr_ptr + LOG_FIFO'(w_push);
    w_idx_nxt     = r_idx;
    if (w_pop) begin
      w_idx_nxt = '0;
    end else if (w_beat) begin
      w_idx_nxt = r_idx + LOG_NUM_RID'(1);
    end
    w_head_nxt    = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? bus.in_rids : r_fifo[w_rd_ptr_nxt];
    w_cnt_nxt     = rids_count(w_head_nxt);
    w_send_nxt    = (w_occ_nxt != '0);
    w_rid_nxt     = '0;
    w_last_nxt    = 1'b0;
    w_nomatch_nxt = 1'b0;
    if (w_send_nxt) begin
      if (w_cnt_nxt == '0) begin
        w_rid_nxt     = NULL_RID;
        w_last_nxt    = 1'b1;
        w_nomatch_nxt = 1'b1;
      end else begin
        w_rid_nxt  = w_head_nxt[int'(w_idx_nxt)*RID_WIDTH +: RID_WIDTH];
        w_last_nxt = ({1'b0, w_idx_nxt} == (w_cnt_nxt - CNT_W'(1)));
      end
    end
  end

  // FIFO storage carries no reset; validity lives in the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.in_rids;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occ         <= '0;
      r_idx         <= '0;
      r_in_ready    <= 1'b1;
      r_overflow    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_rid     <= '0;
      r_out_last    <= 1'b0;
      r_out_nomatch <= 1'b0;
    end else begin
      r_state       <= w_send_nxt ? S_SEND : S_IDLE;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_occ         <= w_occ_nxt;
      r_idx         <= w_idx_nxt;
      r_in_ready    <= (w_occ_nxt != OCC_W'(FIFO_DEPTH));
      if (bus.in_valid && !r_in_ready) begin
        r_overflow <= 1'b1;
      end
      r_out_valid   <= w_send_nxt;
      r_out_rid     <= w_rid_nxt;
      r_out_last    <= w_last_nxt;
      r_out_nomatch <= w_nomatch_nxt;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.overflow    = r_overflow;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_rid     = r_out_rid;
  assign bus.out_last    = r_out_last;
  assign bus.out_nomatch = r_out_nomatch;

endmodule
